// File: rtl/tpu_mem_pkg.sv
// Shared address-mapping helpers for the fixed-latency memory request interface.
// Used by banked_mem_responder and the systolic wrapper.
package tpu_mem_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_BANKING_FACTOR = 1;

    function automatic int unsigned calc_bpw(input int unsigned dw);
        return dw / 8;
    endfunction

    function automatic int unsigned calc_bytes_per_beat(input int unsigned dw, input int unsigned bf);
        return bf * (dw / 8);
    endfunction

    localparam int unsigned BPW            = calc_bpw(DEF_DATA_WIDTH);
    localparam int unsigned BYTES_PER_BEAT = calc_bytes_per_beat(DEF_DATA_WIDTH, DEF_BANKING_FACTOR);

    typedef logic [DEF_BANKING_FACTOR*DEF_DATA_WIDTH-1:0] beat_t;

    // Byte address to word index; sub-word byte offset is discarded.
    function automatic int unsigned word_idx(input int unsigned addr, input int unsigned bpw);
        return addr / bpw;
    endfunction

endpackage

// File: rtl/mem_resp_delay_line.sv
// Valid+data shift register trailing the array read register.
// Data in each stage only moves with a valid beat, so the last stage holds the last result.
module mem_resp_delay_line #(
    parameter int W      = 32,
    parameter int STAGES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         vld_i,
    input  logic [W-1:0] data_i,
    output logic         vld_o,
    output logic [W-1:0] data_o
);

    if (STAGES == 0) begin : g_bypass
        assign vld_o  = vld_i;
        assign data_o = data_i;
    end else begin : g_pipe
        logic [STAGES-1:0]        vld_pipe_q;
        logic [STAGES-1:0][W-1:0] data_pipe_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_pipe_q  <= '0;
                data_pipe_q <= '0;
            end else begin
                vld_pipe_q[0] <= vld_i;
                if (vld_i) data_pipe_q[0] <= data_i;
                for (int s = 1; s < STAGES; s++) begin
                    vld_pipe_q[s] <= vld_pipe_q[s-1];
                    if (vld_pipe_q[s-1]) data_pipe_q[s] <= data_pipe_q[s-1];
                end
            end
        end

        assign vld_o  = vld_pipe_q[STAGES-1];
        assign data_o = data_pipe_q[STAGES-1];
    end

endmodule

// File: rtl/banked_mem_responder.sv
// Fixed-latency banked memory responder: word array, address decode, sticky error flag.
// Optional MEM_RESP_STATS_EN adds saturating read/write request counters.
module banked_mem_responder
    import tpu_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int BANKING_FACTOR = 1,
    parameter int ADDRESS_WIDTH  = 13,
    parameter int MEM_LATENCY    = 2,
    parameter int DEPTH_WORDS    = 2048
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [ADDRESS_WIDTH-1:0]             mem_req_addr,
    input  logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_req_data,
    input  logic                                 mem_read_en,
    input  logic                                 mem_write_en,
    output logic [BANKING_FACTOR*DATA_WIDTH-1:0] mem_resp_data,
    output logic                                 mem_resp_valid,
    output logic                                 mem_err,
    input  logic                                 err_clr
`ifdef MEM_RESP_STATS_EN
    ,
    output logic [31:0]                          stat_rd_cnt,
    output logic [31:0]                          stat_wr_cnt
`endif
);

    localparam int unsigned WBYTES     = calc_bpw(DATA_WIDTH);
    localparam int unsigned BEAT_BYTES = calc_bytes_per_beat(DATA_WIDTH, BANKING_FACTOR);
    localparam int          BW         = BANKING_FACTOR * DATA_WIDTH;
    localparam int          IDXW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [DATA_WIDTH-1:0]                mem_q [DEPTH_WORDS];
    int unsigned                          base_idx;
    logic [BANKING_FACTOR-1:0]            in_rng;
    logic [BANKING_FACTOR-1:0][IDXW-1:0]  widx;
    logic [BW-1:0]                        rd_beat_d;
    logic                                 misalign, err_now;
    logic                                 rd_vld_q;
    logic [BW-1:0]                        rd_data_q;
    logic                                 mem_err_q, mem_err_d;

    always_comb begin
        in_rng    = '0;
        widx      = '0;
        rd_beat_d = '0;
        base_idx  = word_idx(32'(mem_req_addr), WBYTES);
        for (int b = 0; b < BANKING_FACTOR; b++) begin
            in_rng[b] = (base_idx + 32'(b)) < 32'(DEPTH_WORDS);
            widx[b]   = IDXW'(base_idx + 32'(b));
            // A same-cycle write is forwarded so the read sees the new data.
            if (!in_rng[b])
                rd_beat_d[b*DATA_WIDTH +: DATA_WIDTH] = '0;
            else if (mem_write_en)
                rd_beat_d[b*DATA_WIDTH +: DATA_WIDTH] = mem_req_data[b*DATA_WIDTH +: DATA_WIDTH];
            else
                rd_beat_d[b*DATA_WIDTH +: DATA_WIDTH] = mem_q[widx[b]];
        end
    end

    assign misalign = (32'(mem_req_addr) % BEAT_BYTES) != 0;
    assign err_now  = ((mem_read_en || mem_write_en) && (misalign || !(&in_rng)))
                    || (mem_read_en && mem_write_en);

    always_ff @(posedge clk) begin
        if (mem_write_en) begin
            for (int b = 0; b < BANKING_FACTOR; b++) begin
                if (in_rng[b]) mem_q[widx[b]] <= mem_req_data[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q <= mem_read_en;
            if (mem_read_en) rd_data_q <= rd_beat_d;
        end
    end

    mem_resp_delay_line #(
        .W      (BW),
        .STAGES (MEM_LATENCY - 1)
    ) u_delay (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_i  (rd_vld_q),
        .data_i (rd_data_q),
        .vld_o  (mem_resp_valid),
        .data_o (mem_resp_data)
    );

    // A new error outranks a simultaneous clear.
    always_comb begin
        mem_err_d = mem_err_q;
        if (err_now)      mem_err_d = 1'b1;
        else if (err_clr) mem_err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_err_q <= 1'b0;
        else        mem_err_q <= mem_err_d;
    end

    assign mem_err = mem_err_q;

`ifdef MEM_RESP_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (err_clr) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (mem_read_en  && !(&rd_cnt_q)) rd_cnt_q <= rd_cnt_q + 32'd1;
            if (mem_write_en && !(&wr_cnt_q)) wr_cnt_q <= wr_cnt_q + 32'd1;
        end
    end

    assign stat_rd_cnt = rd_cnt_q;
    assign stat_wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_banked_mem_responder.sv
// Scoreboard bench for banked_mem_responder: 4-word beats, 1024-word array, latency 2.
module tb_banked_mem_responder;

    localparam int DW = 32;
    localparam int BF = 4;
    localparam int AW = 13;
    localparam int LAT = 2;
    localparam int BW = DW * BF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] mem_req_addr = '0;
    logic [BW-1:0] mem_req_data = '0;
    logic          mem_read_en = 1'b0;
    logic          mem_write_en = 1'b0;
    logic [BW-1:0] mem_resp_data;
    logic          mem_resp_valid;
    logic          mem_err;
    logic          err_clr = 1'b0;
`ifdef MEM_RESP_STATS_EN
    logic [31:0]   stat_rd_cnt, stat_wr_cnt;
`endif

    banked_mem_responder #(
        .DATA_WIDTH(DW), .BANKING_FACTOR(BF), .ADDRESS_WIDTH(AW),
        .MEM_LATENCY(LAT), .DEPTH_WORDS(1024)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
        .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_resp_data(mem_resp_data), .mem_resp_valid(mem_resp_valid),
        .mem_err(mem_err), .err_clr(err_clr)
`ifdef MEM_RESP_STATS_EN
        , .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [BW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    // Response monitor: every valid beat must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_resp_valid === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp got %h at cycle %0d", mem_resp_data, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (mem_resp_data !== e.data) begin
                    errors++;
                    $display("FAIL resp_data got %h exp %h", mem_resp_data, e.data);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL resp_latency got cycle %0d exp cycle %0d", cyc, e.cyc);
                end
            end
        end
    end

    function automatic logic [BW-1:0] mk(input logic [31:0] w3, w2, w1, w0);
        return {w3, w2, w1, w0};
    endfunction

    function automatic logic [BW-1:0] wv(input int i);
        logic [31:0] b;
        b = 32'hA000 + 32'(i) * 32'd16;
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic req(input logic rd, wr, clr, input logic [AW-1:0] a, input logic [BW-1:0] d);
        @(posedge clk);
        #1;
        mem_read_en  = rd;
        mem_write_en = wr;
        err_clr      = clr;
        mem_req_addr = a;
        mem_req_data = d;
    endtask

    task automatic idle();
        req(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic expect_rd(input logic [BW-1:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + LAT;
        q.push_back(e);
    endtask

    task automatic clr_err();
        req(1'b0, 1'b0, 1'b1, '0, '0);
        idle();
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", BW'(mem_resp_valid), '0);
        chk("rst_data", mem_resp_data, '0);
        chk("rst_err", BW'(mem_err), '0);
        rst_n = 1'b1;

        // basic write then read
        req(1'b0, 1'b1, 1'b0, 13'h0000, mk(0, 0, 0, 32'h11));
        req(1'b1, 1'b0, 1'b0, 13'h0000, '0); expect_rd(mk(0, 0, 0, 32'h11));
        idle(); idle();
        chk("basic_err", BW'(mem_err), '0);

        req(1'b0, 1'b1, 1'b0, 13'h0010, mk(4, 3, 2, 1));
        req(1'b1, 1'b0, 1'b0, 13'h0010, '0); expect_rd(mk(4, 3, 2, 1));

        // eight beats written, then read back-to-back
        for (int i = 0; i < 8; i++) req(1'b0, 1'b1, 1'b0, 13'h0100 + 13'(i * 16), wv(i));
        for (int i = 0; i < 8; i++) begin
            req(1'b1, 1'b0, 1'b0, 13'h0100 + 13'(i * 16), '0);
            expect_rd(wv(i));
        end
        idle(); idle(); idle();
        chk("b2b_err", BW'(mem_err), '0);
        chk("hold_valid", BW'(mem_resp_valid), '0);
        chk("hold_data", mem_resp_data, wv(7));

        // read-after-write in the next cycle
        req(1'b0, 1'b1, 1'b0, 13'h0020, mk(0, 0, 0, 32'hAB));
        req(1'b1, 1'b0, 1'b0, 13'h0020, '0); expect_rd(mk(0, 0, 0, 32'hAB));
        idle();
        chk("raw_err", BW'(mem_err), '0);

        // simultaneous read and write
        req(1'b1, 1'b1, 1'b0, 13'h0030, mk(5, 6, 7, 8)); expect_rd(mk(5, 6, 7, 8));
        idle();
        chk("rdwr_err", BW'(mem_err), {{(BW-1){1'b0}}, 1'b1});
        clr_err();
        chk("clr_err", BW'(mem_err), '0);
        req(1'b1, 1'b0, 1'b0, 13'h0030, '0); expect_rd(mk(5, 6, 7, 8));

        // out-of-range reads
        req(1'b1, 1'b0, 1'b0, 13'h1000, '0); expect_rd('0);
        idle();
        chk("oor_err", BW'(mem_err), {{(BW-1){1'b0}}, 1'b1});
        clr_err();
        req(1'b1, 1'b0, 1'b0, 13'h1FFC, '0); expect_rd('0);
        idle();
        chk("oor_top_err", BW'(mem_err), {{(BW-1){1'b0}}, 1'b1});
        clr_err();
        chk("oor_clr", BW'(mem_err), '0);

        // misaligned access proceeds at truncated word; error beats clear
        req(1'b1, 1'b0, 1'b0, 13'h0002, '0); expect_rd(mk(0, 0, 0, 32'h11));
        idle();
        chk("misalign_err", BW'(mem_err), {{(BW-1){1'b0}}, 1'b1});
        req(1'b1, 1'b0, 1'b1, 13'h0002, '0); expect_rd(mk(0, 0, 0, 32'h11));
        idle();
        chk("err_beats_clr", BW'(mem_err), {{(BW-1){1'b0}}, 1'b1});
        clr_err();
        chk("misalign_clr", BW'(mem_err), '0);
        idle(); idle();

        // reset while a read is in flight: its response must never appear
        req(1'b1, 1'b0, 1'b0, 13'h0010, '0);
        @(posedge clk);
        #3;
        mem_read_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_data", mem_resp_data, '0);
        chk("midrst_valid", BW'(mem_resp_valid), '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(); idle(); idle();
        req(1'b1, 1'b0, 1'b0, 13'h0010, '0); expect_rd(mk(4, 3, 2, 1));
        idle(); idle(); idle();

`ifdef MEM_RESP_STATS_EN
        clr_err();
        chk("stat_rd_clr0", BW'(stat_rd_cnt), '0);
        chk("stat_wr_clr0", BW'(stat_wr_cnt), '0);
        for (int i = 0; i < 3; i++) begin
            req(1'b1, 1'b0, 1'b0, 13'h0000, '0);
            expect_rd(mk(0, 0, 0, 32'h11));
        end
        req(1'b0, 1'b1, 1'b0, 13'h0040, mk(9, 9, 9, 9));
        req(1'b0, 1'b1, 1'b0, 13'h0050, mk(7, 7, 7, 7));
        idle();
        chk("stat_rd", BW'(stat_rd_cnt), BW'(3));
        chk("stat_wr", BW'(stat_wr_cnt), BW'(2));
        clr_err();
        chk("stat_rd_clr", BW'(stat_rd_cnt), '0);
        chk("stat_wr_clr", BW'(stat_wr_cnt), '0);
        idle(); idle();
`endif

        repeat (4) idle();
        chk("queue_drained", BW'(q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
